z80_bus_responder: RTL and testbench

//  Parametrised memory + I/O slave for tv80s-based benches and SoC sims. It replaces ad-hoc negedge mem arrays.

---
 rtl/z80bus_pkg.sv | 43 ++++
 rtl/z80bus_trace_fifo.sv | 67 ++++++
 rtl/z80_bus_responder.sv | 178 +++++++++++++++++
 tb/tb_z80_bus_responder.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/z80bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : z80bus_pkg
//  Purpose  : Shared types for the Z80 bus responder: FSM states, bus cycle
//             kinds, trace entry layout and small kind-classification helpers.
//  Revision : 1.0  initial release
// ============================================================================
package z80bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    HOLD   = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    MEM_RD = 3'd0,
    MEM_WR = 3'd1,
    IO_RD  = 3'd2,
    IO_WR  = 3'd3,
    IACK   = 3'd4
  } kind_t;

  typedef struct packed {
    logic        is_io;
    logic [15:0] addr;
    logic [7:0]  data;
  } trace_entry_t;

  localparam int c_TRACE_W = $bits(trace_entry_t);

  function automatic logic kind_is_write(input kind_t k);
    return (k == MEM_WR) || (k == IO_WR);
  endfunction

  // Interrupt-acknowledge is an IORQ cycle, so it takes the I/O wait count.
  function automatic logic kind_is_io(input kind_t k);
    return (k == IO_RD) || (k == IO_WR) || (k == IACK);
  endfunction

endpackage
`default_nettype wire

// File: rtl/z80bus_trace_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : z80bus_trace_fifo
//  Purpose  : First-word-fall-through FIFO capturing committed bus writes.
//             A push into a full FIFO is dropped and sets a sticky overflow
//             flag, unless a pop happens in the same clock.
//  Revision : 1.0  initial release
// ============================================================================
module z80bus_trace_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_ovf
);

  localparam int              c_AW   = $clog2(DEPTH);
  localparam logic [c_AW:0]   c_FULL = (c_AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_buf [0:DEPTH-1];
  logic [c_AW-1:0]  r_wptr;
  logic [c_AW-1:0]  r_rptr;
  logic [c_AW:0]    r_count;
  logic             r_ovf;
  logic             w_pop_ok;
  logic             w_push_ok;

  // A simultaneous pop frees the slot the push needs, so full+push+pop is kept.
  assign w_pop_ok  = i_pop && (r_count != '0);
  assign w_push_ok = i_push && ((r_count != c_FULL) || w_pop_ok);

  // Storage is not reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_buf[r_wptr] <= i_data;
  end

  // Pointer, occupancy and sticky-overflow bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + c_AW'(1);
      if (w_pop_ok)  r_rptr <= r_rptr + c_AW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + (c_AW+1)'(1);
        2'b01:   r_count <= r_count - (c_AW+1)'(1);
        default: r_count <= r_count;
      endcase
      if (i_push && !w_push_ok) r_ovf <= 1'b1;
    end
  end

  assign o_valid = (r_count != '0);
  assign o_data  = r_buf[r_rptr];
  assign o_ovf   = r_ovf;

endmodule
`default_nettype wire

// File: rtl/z80_bus_responder.sv
`default_nettype none
// ============================================================================
//  Module   : z80_bus_responder
//  Purpose  : Memory + I/O slave for tv80-style buses. Edge-started cycles,
//             programmable wait states, I/O mapped into a page of the shared
//             byte array, interrupt-ack vector, write counters, backdoor port.
//             Optional write-trace FIFO enabled by defining Z80BUS_TRACE_EN.
//  Revision : 1.0  initial release
// ============================================================================
module z80_bus_responder
  import z80bus_pkg::*;
#(
  parameter int         ADDR_W      = 16,
  parameter logic [7:0] IO_PAGE     = 8'h10,
  parameter int         MEM_WAIT    = 0,
  parameter int         IO_WAIT     = 1,
  parameter logic [7:0] IACK_VEC    = 8'hFF,
  parameter int         TRACE_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m1_n,
  input  logic              mreq_n,
  input  logic              iorq_n,
  input  logic              rd_n,
  input  logic              wr_n,
  input  logic              rfsh_n,
  input  logic [15:0]       A,
  input  logic [7:0]        dout,
  output logic [7:0]        di,
  output logic              wait_n,
  input  logic              bd_we,
  input  logic [ADDR_W-1:0] bd_addr,
  input  logic [7:0]        bd_wdata,
  output logic [7:0]        bd_rdata,
  output logic [15:0]       mem_wr_cnt,
  output logic [15:0]       io_wr_cnt,
  input  logic              trc_pop,
  output logic              trc_valid,
  output logic [24:0]       trc_data,
  output logic              trc_ovf
);

  localparam logic [3:0] c_MEM_WAIT = 4'(MEM_WAIT);
  localparam logic [3:0] c_IO_WAIT  = 4'(IO_WAIT);

  logic [7:0]        r_mem [0:(1<<ADDR_W)-1];
  state_t            r_state, w_state_nxt;
  logic [3:0]        r_wcnt, w_wcnt_nxt;
  kind_t             r_kind, w_kind_dec;
  logic [ADDR_W-1:0] r_addr, w_addr_dec;
  logic              r_req_q, w_req, w_start, w_capture, w_do_write;
  logic [15:0]       w_io_addr;
  logic [3:0]        w_wait_ld;
  logic [7:0]        r_di;
  logic [15:0]       r_mem_cnt, r_io_cnt;

  // Refresh cycles are excluded from memory requests; IORQ+M1 alone is an int-ack.
  assign w_req   = (!mreq_n && rfsh_n && (!rd_n || !wr_n)) ||
                   (!iorq_n && (!rd_n || !wr_n || !m1_n));
  assign w_start = w_req && !r_req_q;

  // Classify the cycle at its start and form the array address (upper bits alias).
  assign w_io_addr  = {IO_PAGE, A[7:0]};
  always_comb begin
    w_kind_dec = MEM_RD;
    if (!iorq_n && !m1_n)      w_kind_dec = IACK;
    else if (!iorq_n && !wr_n) w_kind_dec = IO_WR;
    else if (!iorq_n)          w_kind_dec = IO_RD;
    else if (!wr_n)            w_kind_dec = MEM_WR;
    w_addr_dec = kind_is_io(w_kind_dec) ? w_io_addr[ADDR_W-1:0] : A[ADDR_W-1:0];
    w_wait_ld  = kind_is_io(w_kind_dec) ? c_IO_WAIT : c_MEM_WAIT;
  end

  // FSM state, wait counter, captured cycle info and request edge detector.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_wcnt  <= '0;
      r_kind  <= MEM_RD;
      r_addr  <= '0;
      r_req_q <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
      r_req_q <= w_req;
      if (w_capture) begin
        r_kind <= w_kind_dec;
        r_addr <= w_addr_dec;
      end
    end
  end

  // Next-state logic; wait_n is decoded from state so reset releases it at once.
  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_capture = 1'b1;
          if (w_wait_ld != 4'd0) begin
            w_state_nxt = WAIT;
            w_wcnt_nxt  = w_wait_ld;
          end else begin
            w_state_nxt = ACCESS;
          end
        end
      end
      WAIT: begin
        w_wcnt_nxt = r_wcnt - 4'd1;
        if (r_wcnt <= 4'd1) w_state_nxt = ACCESS;
      end
      ACCESS:  w_state_nxt = HOLD;
      HOLD:    if (!w_req) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign wait_n     = (r_state != WAIT);
  assign w_do_write = (r_state == ACCESS) && kind_is_write(r_kind);

  // Byte array: bus write first, backdoor last so it wins on an address clash.
  always_ff @(posedge clk) begin
    if (w_do_write) r_mem[r_addr] <= dout;
    if (bd_we)      r_mem[bd_addr] <= bd_wdata;
  end

  // Read data register and write counters, updated only in the ACCESS clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_di      <= 8'hFF;
      r_mem_cnt <= '0;
      r_io_cnt  <= '0;
    end else if (r_state == ACCESS) begin
      case (r_kind)
        MEM_RD, IO_RD: r_di      <= r_mem[r_addr];
        IACK:          r_di      <= IACK_VEC;
        MEM_WR:        r_mem_cnt <= r_mem_cnt + 16'd1;
        IO_WR:         r_io_cnt  <= r_io_cnt + 16'd1;
        default:       r_di      <= r_di;
      endcase
    end
  end

  assign di         = r_di;
  assign bd_rdata   = r_mem[bd_addr];
  assign mem_wr_cnt = r_mem_cnt;
  assign io_wr_cnt  = r_io_cnt;

`ifdef Z80BUS_TRACE_EN
  trace_entry_t w_trace_entry;
  assign w_trace_entry = '{is_io: kind_is_io(r_kind), addr: 16'(r_addr), data: dout};

  z80bus_trace_fifo #(
    .DEPTH (TRACE_DEPTH),
    .WIDTH (c_TRACE_W)
  ) u_trace_fifo (
    .clk     (clk),
    .rst     (reset),
    .i_push  (w_do_write),
    .i_data  (w_trace_entry),
    .i_pop   (trc_pop),
    .o_valid (trc_valid),
    .o_data  (trc_data),
    .o_ovf   (trc_ovf)
  );
`else
  logic w_unused_trc_pop;
  assign w_unused_trc_pop = trc_pop;
  assign trc_valid = 1'b0;
  assign trc_data  = '0;
  assign trc_ovf   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_z80_bus_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_z80_bus_responder
//  Purpose  : Self-checking bench: directed bus scenarios plus randomized
//             cycles compared against a flat-array reference memory.
//  Revision : 1.0  initial release
// ============================================================================
module tb_z80_bus_responder;

  localparam int         ADDR_W      = 16;
  localparam logic [7:0] IO_PAGE     = 8'h10;
  localparam int         MEM_WAIT    = 2;
  localparam int         IO_WAIT     = 1;
  localparam logic [7:0] IACK_VEC    = 8'hFF;
  localparam int         TRACE_DEPTH = 8;

  localparam int K_MEM_RD = 0, K_MEM_WR = 1, K_IO_RD = 2, K_IO_WR = 3, K_IACK = 4;

  logic        clk = 1'b0, reset = 1'b1;
  logic        m1_n = 1, mreq_n = 1, iorq_n = 1, rd_n = 1, wr_n = 1, rfsh_n = 1;
  logic [15:0] A = '0;
  logic [7:0]  dout = '0, di;
  logic        wait_n;
  logic        bd_we = 0;
  logic [15:0] bd_addr = '0;
  logic [7:0]  bd_wdata = '0, bd_rdata;
  logic [15:0] mem_wr_cnt, io_wr_cnt;
  logic        trc_pop = 0, trc_valid, trc_ovf;
  logic [24:0] trc_data;

  z80_bus_responder #(
    .ADDR_W(ADDR_W), .IO_PAGE(IO_PAGE), .MEM_WAIT(MEM_WAIT), .IO_WAIT(IO_WAIT),
    .IACK_VEC(IACK_VEC), .TRACE_DEPTH(TRACE_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .m1_n(m1_n), .mreq_n(mreq_n), .iorq_n(iorq_n),
    .rd_n(rd_n), .wr_n(wr_n), .rfsh_n(rfsh_n), .A(A), .dout(dout), .di(di),
    .wait_n(wait_n), .bd_we(bd_we), .bd_addr(bd_addr), .bd_wdata(bd_wdata),
    .bd_rdata(bd_rdata), .mem_wr_cnt(mem_wr_cnt), .io_wr_cnt(io_wr_cnt),
    .trc_pop(trc_pop), .trc_valid(trc_valid), .trc_data(trc_data), .trc_ovf(trc_ovf)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  ref_mem [0:65535];
  int          ref_mem_cnt = 0;
  int          ref_io_cnt  = 0;
  logic [24:0] exp_trace [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] eff_addr(input int kind, input logic [15:0] a);
    if (kind == K_IO_RD || kind == K_IO_WR || kind == K_IACK) return {IO_PAGE, a[7:0]};
    return a;
  endfunction

  task automatic bd_write(input logic [15:0] a, input logic [7:0] v);
    @(negedge clk);
    bd_we = 1; bd_addr = a; bd_wdata = v;
    @(negedge clk);
    bd_we = 0;
    ref_mem[a] = v;
  endtask

  task automatic release_bus();
    m1_n = 1; mreq_n = 1; iorq_n = 1; rd_n = 1; wr_n = 1; rfsh_n = 1;
  endtask

  task automatic check_counters(input string tag);
    chk({tag, ".mem_wr_cnt"}, mem_wr_cnt, ref_mem_cnt[15:0]);
    chk({tag, ".io_wr_cnt"},  io_wr_cnt,  ref_io_cnt[15:0]);
  endtask

  // One complete bus cycle; extra_hold keeps strobes asserted past the access.
  task automatic do_cycle(input string tag, input int kind, input logic [15:0] a,
                          input logic [7:0] d, input int extra_hold,
                          input bit collide, input logic [7:0] bd_val);
    int          n_low;
    logic [15:0] ea;
    int          exp_wait;
    bit          is_wr;
    ea       = eff_addr(kind, a);
    is_wr    = (kind == K_MEM_WR) || (kind == K_IO_WR);
    exp_wait = (kind == K_MEM_RD || kind == K_MEM_WR) ? MEM_WAIT : IO_WAIT;
    @(negedge clk);
    A = a; dout = d;
    case (kind)
      K_MEM_RD: begin mreq_n = 0; rd_n = 0; m1_n = 1'($urandom_range(0, 1)); end
      K_MEM_WR: begin mreq_n = 0; wr_n = 0; end
      K_IO_RD:  begin iorq_n = 0; rd_n = 0; end
      K_IO_WR:  begin iorq_n = 0; wr_n = 0; end
      default:  begin iorq_n = 0; m1_n = 0; end
    endcase
    @(posedge clk); #1;
    n_low = 0;
    while (!wait_n && n_low < 20) begin
      n_low++;
      @(posedge clk); #1;
    end
    if (collide) begin bd_we = 1; bd_addr = ea; bd_wdata = bd_val; end
    @(posedge clk); #1;
    bd_we = 0;
    chk({tag, ".waits"}, n_low, exp_wait);
    if (kind == K_IACK)                         chk({tag, ".di"}, di, IACK_VEC);
    else if (kind == K_MEM_RD || kind == K_IO_RD) chk({tag, ".di"}, di, ref_mem[ea]);
    if (is_wr) begin
      ref_mem[ea] = collide ? bd_val : d;
      if (kind == K_MEM_WR) ref_mem_cnt++; else ref_io_cnt++;
      exp_trace.push_back({(kind == K_IO_WR), ea, d});
    end
    repeat (extra_hold) @(posedge clk);
    @(negedge clk);
    release_bus();
    @(posedge clk); @(posedge clk); #1;
    check_counters(tag);
    if (is_wr) begin
      bd_addr = ea; #1;
      chk({tag, ".bd_rdata"}, bd_rdata, ref_mem[ea]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] pool_mem [8];
    logic [7:0]  pool_io  [8];
    logic [15:0] ry;
    logic [7:0]  rv;

    repeat (3) @(posedge clk);
    #1;
    chk("reset.di", di, 8'hFF);
    chk("reset.wait_n", wait_n, 1'b1);
    check_counters("reset");
    chk("reset.trc_valid", trc_valid, 1'b0);
    chk("reset.trc_ovf", trc_ovf, 1'b0);
    @(negedge clk) reset = 0;

    // Memory read with wait states, then write, I/O write/read, int-ack.
    bd_write(16'hB488, 8'h44);
    do_cycle("memrd_B488", K_MEM_RD, 16'hB488, 8'h00, 0, 0, 8'h00);
    do_cycle("memwr_B488", K_MEM_WR, 16'hB488, 8'h22, 0, 0, 8'h00);
    do_cycle("iowr_2D", K_IO_WR, 16'h7F2D, 8'h5A, 0, 0, 8'h00);
    bd_addr = 16'h102D; #1;
    chk("iowr_2D.mem102D", bd_rdata, 8'h5A);
    do_cycle("iord_2D", K_IO_RD, 16'hC32D, 8'h00, 0, 0, 8'h00);
    do_cycle("iack", K_IACK, 16'h0000, 8'h00, 0, 0, 8'h00);

    // Refresh with mreq and wr asserted must not start a cycle.
    bd_write(16'h0050, 8'h3C);
    @(negedge clk);
    A = 16'h0050; dout = 8'hC3; mreq_n = 0; rfsh_n = 0; wr_n = 0;
    rv = 0;
    repeat (4) begin @(posedge clk); #1; if (!wait_n) rv++; end
    chk("rfsh.no_wait", rv, 8'd0);
    @(negedge clk) release_bus();
    repeat (2) @(posedge clk); #1;
    check_counters("rfsh");
    bd_addr = 16'h0050; #1;
    chk("rfsh.mem_unchanged", bd_rdata, 8'h3C);

    // Strobes held long after the access: still exactly one write.
    do_cycle("held_req", K_MEM_WR, 16'h2222, 8'hA5, 10, 0, 8'h00);
    // Backdoor in the access clock of a bus write to the same address.
    bd_write(16'h3333, 8'h11);
    do_cycle("bd_clash", K_MEM_WR, 16'h3333, 8'h77, 0, 1, 8'h99);

    // Reset in the second wait clock of a write.
    bd_write(16'h4444, 8'h6E);
    @(negedge clk);
    A = 16'h4444; dout = 8'h91; mreq_n = 0; wr_n = 0;
    @(posedge clk); #1;
    chk("rstmid.wait1", wait_n, 1'b0);
    @(posedge clk); #1;
    chk("rstmid.wait2", wait_n, 1'b0);
    reset = 1; #1;
    chk("rstmid.release", wait_n, 1'b1);
    @(negedge clk) release_bus();
    @(posedge clk);
    @(negedge clk) reset = 0;
    ref_mem_cnt = 0; ref_io_cnt = 0;
    exp_trace.delete();
    @(posedge clk); @(posedge clk); #1;
    bd_addr = 16'h4444; #1;
    chk("rstmid.target", bd_rdata, 8'h6E);
    chk("rstmid.di", di, 8'hFF);
    check_counters("rstmid");
    do_cycle("rstmid.after", K_MEM_RD, 16'h4444, 8'h00, 0, 0, 8'h00);

`ifdef Z80BUS_TRACE_EN
    for (int i = 0; i < 9; i++)
      do_cycle("trc_fill", K_MEM_WR, 16'h6000 + 16'(i * 3), 8'(8'h30 + i), 0, 0, 8'h00);
    #1;
    chk("trc.ovf", trc_ovf, 1'b1);
    for (int i = 0; i < TRACE_DEPTH; i++) begin
      chk("trc.valid", trc_valid, 1'b1);
      chk("trc.data", trc_data, exp_trace[i]);
      @(negedge clk) trc_pop = 1;
      @(posedge clk); #1;
      trc_pop = 0;
    end
    chk("trc.empty", trc_valid, 1'b0);
    chk("trc.ovf_sticky", trc_ovf, 1'b1);
`else
    @(negedge clk) trc_pop = 1;
    @(negedge clk) trc_pop = 0;
    chk("notrc.valid", trc_valid, 1'b0);
    chk("notrc.data", trc_data, 25'd0);
    chk("notrc.ovf", trc_ovf, 1'b0);
`endif

    // Randomized cycles over a preloaded address pool.
    for (int i = 0; i < 8; i++) begin
      pool_mem[i] = 16'($urandom);
      pool_io[i]  = 8'($urandom);
      bd_write(pool_mem[i], 8'($urandom));
      bd_write({IO_PAGE, pool_io[i]}, 8'($urandom));
    end
    for (int i = 0; i < 40; i++) begin
      int k;
      k  = int'($urandom_range(0, 4));
      rv = 8'($urandom);
      if (k == K_MEM_RD || k == K_MEM_WR) ry = pool_mem[$urandom_range(0, 7)];
      else ry = {8'($urandom), pool_io[$urandom_range(0, 7)]};
      do_cycle("rand", k, ry, rv, int'($urandom_range(0, 2)), 0, 8'h00);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
